multi_channel_reference_reader: RTL and testbench



---
 rtl/multi_channel_reference_reader.sv | 242 ++++++++++++++++++++++++
 tb/tb_multi_channel_reference_reader.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_reference_reader.sv
// ---------------------------------------------------------------------------
// multi_channel_reference_reader
//
// Serves reference-sequence fetch requests from NUM_CH Smith-Waterman engine
// channels over one shared AXI read-arbiter port. Each request (start block,
// length in blocks) is cut into bursts of at most MAX_BURST_BEATS beats.
// Bursts are granted round-robin, one burst at a time, so a long reference
// cannot starve the other channels. Returned 256-bit beats are gathered into
// 2*REF_LENGTH-bit blocks and handed to each channel through a one-deep
// output slot with a valid/ready handshake.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   ref_addr_in               per-channel start block index (25 b each)
//   ref_length_in             per-channel length in blocks (25 b each)
//   ref_info_valid_in         per-channel request valid
//   ref_info_rdy_out          per-channel idle; request taken on valid&rdy
//   ref_seq_block_out         per-channel reference block
//   ref_seq_block_valid_out   per-channel block valid
//   ref_seq_block_rdy_in      per-channel block accepted
//   ref_done_out              per-channel pulse after the last block hand-off
//   rd_id_out                 granted channel index, zero-extended
//   rd_addr_out               burst byte address
//   rd_len_out                burst beats minus one
//   rd_info_valid_out         burst request valid
//   rd_info_rdy_in            burst request accepted
//   rd_data_in                read beat
//   rd_data_valid_in          read beat valid
//   rd_data_rdy_out           read beat accepted
// ---------------------------------------------------------------------------
module multi_channel_reference_reader #(
   parameter int          NUM_CH          = 4,
   parameter int          REF_LENGTH      = 128,
   parameter int          MAX_BURST_BEATS = 16,
   parameter logic [31:0] BASE_ADDR       = 32'h0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH*25-1:0]           ref_addr_in,
   input  logic [NUM_CH*25-1:0]           ref_length_in,
   input  logic [NUM_CH-1:0]              ref_info_valid_in,
   output logic [NUM_CH-1:0]              ref_info_rdy_out,
   output logic [NUM_CH*2*REF_LENGTH-1:0] ref_seq_block_out,
   output logic [NUM_CH-1:0]              ref_seq_block_valid_out,
   input  logic [NUM_CH-1:0]              ref_seq_block_rdy_in,
   output logic [NUM_CH-1:0]              ref_done_out,
   output logic [5:0]                     rd_id_out,
   output logic [31:0]                    rd_addr_out,
   output logic [7:0]                     rd_len_out,
   output logic                           rd_info_valid_out,
   input  logic                           rd_info_rdy_in,
   input  logic [255:0]                   rd_data_in,
   input  logic                           rd_data_valid_in,
   output logic                           rd_data_rdy_out
);

   localparam int          BW        = 2 * REF_LENGTH;
   localparam int          BEATS     = BW / 256;
   localparam int          BPB       = MAX_BURST_BEATS / BEATS;   // blocks per burst
   localparam int          GW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int          BIDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [31:0] BLK_BYTES = 32'(REF_LENGTH / 4);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   // Burst engine state
   state_t            r_state;
   logic [GW-1:0]     r_grant;
   logic [GW-1:0]     r_last_grant;
   logic [8:0]        r_blocks;
   logic [8:0]        r_beats_left;
   logic [BIDX_W-1:0] r_beat_idx;
   logic [BW-1:0]     r_gather;
   logic              r_rd_valid;
   logic [5:0]        r_rd_id;
   logic [31:0]       r_rd_addr;
   logic [7:0]        r_rd_len;

   // Per-channel state
   logic [24:0]       r_cur_addr   [NUM_CH];
   logic [24:0]       r_remaining  [NUM_CH];
   logic [BW-1:0]     r_slot_data  [NUM_CH];
   logic [NUM_CH-1:0] r_busy;
   logic [NUM_CH-1:0] r_slot_valid;
   logic [NUM_CH-1:0] r_done;

   logic              w_found;
   logic [GW-1:0]     w_next;
   logic [8:0]        w_blocks;
   logic              w_final_blk;
   logic              w_slot_free;
   logic              w_data_rdy;
   logic              w_beat_acc;
   logic              w_load;
   logic              w_addr_acc;
   logic [BW-1:0]     w_block;

   // Round-robin search starting one past the last grant, wrapping.
   always_comb begin
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_next  = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = int'(r_last_grant) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (!w_found && r_busy[idx] && (r_remaining[idx] != '0)) begin
            w_found = 1'b1;
            w_next  = GW'(idx);
         end
      end
   end

   assign w_blocks = (r_remaining[w_next] < 25'(BPB)) ? r_remaining[w_next][8:0] : 9'(BPB);

   // Only the beat that completes a block needs room in the output slot;
   // a slot being drained this cycle counts as room.
   assign w_final_blk = (r_beat_idx == BIDX_W'(BEATS - 1));
   assign w_slot_free = !r_slot_valid[r_grant] || ref_seq_block_rdy_in[r_grant];
   assign w_data_rdy  = (r_state == S_DATA) && (!w_final_blk || w_slot_free);
   assign w_beat_acc  = w_data_rdy && rd_data_valid_in;
   assign w_load      = w_beat_acc && w_final_blk;
   assign w_addr_acc  = (r_state == S_ADDR) && rd_info_rdy_in;

   // Current beat dropped into its lane on top of the beats gathered so far.
   always_comb begin
      w_block = r_gather;
      for (int k = 0; k < BEATS; k++) begin
         if (r_beat_idx == BIDX_W'(k)) w_block[256*k +: 256] = rd_data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_grant      <= '0;
         r_last_grant <= GW'(NUM_CH - 1);
         r_blocks     <= '0;
         r_beats_left <= '0;
         r_beat_idx   <= '0;
         r_gather     <= '0;
         r_rd_valid   <= 1'b0;
         r_rd_id      <= '0;
         r_rd_addr    <= '0;
         r_rd_len     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant      <= w_next;
                  r_last_grant <= w_next;
                  r_blocks     <= w_blocks;
                  r_beats_left <= 9'(int'(w_blocks) * BEATS);
                  r_beat_idx   <= '0;
                  r_rd_valid   <= 1'b1;
                  r_rd_id      <= 6'(w_next);
                  r_rd_addr    <= BASE_ADDR + 32'(r_cur_addr[w_next]) * BLK_BYTES;
                  r_rd_len     <= 8'(int'(w_blocks) * BEATS - 1);
                  r_state      <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (rd_info_rdy_in) begin
                  r_rd_valid <= 1'b0;
                  r_state    <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_beat_acc) begin
                  r_beats_left <= r_beats_left - 9'd1;
                  if (w_final_blk) begin
                     r_beat_idx <= '0;
                  end else begin
                     r_beat_idx <= r_beat_idx + BIDX_W'(1);
                     r_gather   <= w_block;
                  end
                  if (r_beats_left == 9'd1) r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_cur_addr[c]  <= '0;
            r_remaining[c] <= '0;
            r_slot_data[c] <= '0;
         end
         r_busy       <= '0;
         r_slot_valid <= '0;
         r_done       <= '0;
      end else begin
         r_done <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (ref_info_valid_in[c] && !r_busy[c]) begin
               // A zero-length request completes without touching the bus.
               if (ref_length_in[c*25 +: 25] == '0) begin
                  r_done[c] <= 1'b1;
               end else begin
                  r_busy[c]      <= 1'b1;
                  r_cur_addr[c]  <= ref_addr_in[c*25 +: 25];
                  r_remaining[c] <= ref_length_in[c*25 +: 25];
               end
            end
            if (w_addr_acc && (r_grant == GW'(c))) begin
               r_cur_addr[c]  <= r_cur_addr[c] + 25'(r_blocks);
               r_remaining[c] <= r_remaining[c] - 25'(r_blocks);
            end
            if (w_load && (r_grant == GW'(c))) begin
               r_slot_valid[c] <= 1'b1;
               r_slot_data[c]  <= w_block;
            end else if (r_slot_valid[c] && ref_seq_block_rdy_in[c]) begin
               r_slot_valid[c] <= 1'b0;
               // Request finishes once nothing is left to fetch and no burst
               // for this channel is still in flight.
               if (r_busy[c] && (r_remaining[c] == '0) &&
                   !((r_state != S_IDLE) && (r_grant == GW'(c)))) begin
                  r_done[c] <= 1'b1;
                  r_busy[c] <= 1'b0;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign ref_seq_block_out[g*BW +: BW] = r_slot_data[g];
   end

   assign ref_info_rdy_out        = ~r_busy;
   assign ref_seq_block_valid_out = r_slot_valid;
   assign ref_done_out            = r_done;
   assign rd_id_out               = r_rd_id;
   assign rd_addr_out             = r_rd_addr;
   assign rd_len_out              = r_rd_len;
   assign rd_info_valid_out       = r_rd_valid;
   assign rd_data_rdy_out         = w_data_rdy;

endmodule

// File: tb/tb_multi_channel_reference_reader.sv
module tb_multi_channel_reference_reader;

   typedef struct { int id; logic [31:0] addr; int len; } burst_t;
   typedef struct { int ch; logic [255:0] d; } blk_t;

   logic clk;
   logic rst;

   // DUT A: 4 channels, REF_LENGTH=128 (one beat per block)
   logic [99:0]   a_addr_in, a_len_in;
   logic [3:0]    a_ivalid_in, a_irdy_out, a_bvalid, a_brdy, a_done;
   logic [1023:0] a_bdata;
   logic [5:0]    a_id;
   logic [31:0]   a_addr;
   logic [7:0]    a_len;
   logic          a_ivalid, a_info_rdy, a_dvalid, a_drdy;
   logic [255:0]  a_ddata;

   // DUT B: 2 channels, REF_LENGTH=256 (two beats per block)
   logic [49:0]   b_addr_in, b_len_in;
   logic [1:0]    b_ivalid_in, b_irdy_out, b_bvalid, b_brdy, b_done;
   logic [1023:0] b_bdata;
   logic [5:0]    b_id;
   logic [31:0]   b_addr;
   logic [7:0]    b_len;
   logic          b_ivalid, b_info_rdy, b_dvalid, b_drdy;
   logic [255:0]  b_ddata;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   burst_t burst_q[$];
   blk_t   blk_q[$];
   int     done_order[$];
   int     done_cnt [4];
   int     done_cyc [4];
   int     hand_cyc [4];

   multi_channel_reference_reader #(
      .NUM_CH(4), .REF_LENGTH(128), .MAX_BURST_BEATS(16), .BASE_ADDR(32'h0)
   ) dut_a (
      .clk(clk), .rst(rst),
      .ref_addr_in(a_addr_in), .ref_length_in(a_len_in),
      .ref_info_valid_in(a_ivalid_in), .ref_info_rdy_out(a_irdy_out),
      .ref_seq_block_out(a_bdata), .ref_seq_block_valid_out(a_bvalid),
      .ref_seq_block_rdy_in(a_brdy), .ref_done_out(a_done),
      .rd_id_out(a_id), .rd_addr_out(a_addr), .rd_len_out(a_len),
      .rd_info_valid_out(a_ivalid), .rd_info_rdy_in(a_info_rdy),
      .rd_data_in(a_ddata), .rd_data_valid_in(a_dvalid), .rd_data_rdy_out(a_drdy)
   );

   multi_channel_reference_reader #(
      .NUM_CH(2), .REF_LENGTH(256), .MAX_BURST_BEATS(16), .BASE_ADDR(32'h0)
   ) dut_b (
      .clk(clk), .rst(rst),
      .ref_addr_in(b_addr_in), .ref_length_in(b_len_in),
      .ref_info_valid_in(b_ivalid_in), .ref_info_rdy_out(b_irdy_out),
      .ref_seq_block_out(b_bdata), .ref_seq_block_valid_out(b_bvalid),
      .ref_seq_block_rdy_in(b_brdy), .ref_done_out(b_done),
      .rd_id_out(b_id), .rd_addr_out(b_addr), .rd_len_out(b_len),
      .rd_info_valid_out(b_ivalid), .rd_info_rdy_in(b_info_rdy),
      .rd_data_in(b_ddata), .rd_data_valid_in(b_dvalid), .rd_data_rdy_out(b_drdy)
   );

   function automatic logic [255:0] pat(input logic [31:0] a);
      pat = {8{a}};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory model for DUT A: beat data is the beat's byte address repeated.
   initial begin : slave_a
      int          pend;
      logic [31:0] baddr;
      pend = 0; baddr = '0;
      a_dvalid = 1'b0; a_ddata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend = 0; a_dvalid = 1'b0;
         end else if (pend == 0) begin
            a_dvalid = 1'b0;
            if (a_ivalid) begin
               pend  = int'(a_len) + 1;
               baddr = a_addr;
            end
         end else begin
            a_dvalid = 1'b1;
            a_ddata  = pat(baddr);
            #4;
            if (a_drdy && !rst) begin
               pend--;
               baddr += 32;
            end
         end
      end
   end

   // Observer for DUT A: logs bursts, block hand-offs and done pulses.
   initial begin : monitor_a
      burst_t bt;
      blk_t   bk;
      forever begin
         @(negedge clk);
         #4;
         if (!rst) begin
            if (a_ivalid && a_info_rdy) begin
               bt.id = int'(a_id); bt.addr = a_addr; bt.len = int'(a_len);
               burst_q.push_back(bt);
            end
            for (int c = 0; c < 4; c++) begin
               if (a_bvalid[c] && a_brdy[c]) begin
                  bk.ch = c; bk.d = a_bdata[c*256 +: 256];
                  blk_q.push_back(bk);
                  hand_cyc[c] = cyc;
               end
               if (a_done[c]) begin
                  done_cnt[c]++;
                  done_cyc[c] = cyc;
                  done_order.push_back(c);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic clear_logs();
      burst_q.delete();
      blk_q.delete();
      done_order.delete();
      for (int c = 0; c < 4; c++) begin
         done_cnt[c] = 0; done_cyc[c] = -1; hand_cyc[c] = -1;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic wait_done(input int c, input int bound, input string name);
      int i;
      i = 0;
      while (done_cnt[c] == 0 && i < bound) begin
         @(negedge clk);
         i++;
      end
      n_tests++;
      if (done_cnt[c] == 0) begin
         n_fail++;
         $display("FAIL %s_timeout: no done pulse on ch%0d within %0d cycles", name, c, bound);
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if (a_irdy_out !== 4'hF || b_irdy_out !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_rdy: got %h/%h required f/3", a_irdy_out, b_irdy_out);
      end
      n_tests++;
      if ({a_ivalid, a_drdy, a_bvalid, a_done} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 0", {a_ivalid, a_drdy, a_bvalid, a_done});
      end
      n_tests++;
      if ({a_id, a_addr, a_len} !== 46'b0 || a_bdata !== '0) begin
         n_fail++;
         $display("FAIL reset_data: id %h addr %h len %h required 0", a_id, a_addr, a_len);
      end
   endtask

   task automatic test_single();
      clear_logs();
      @(negedge clk);
      a_addr_in[0 +: 25] = 25'd3; a_len_in[0 +: 25] = 25'd2; a_ivalid_in[0] = 1'b1;
      @(negedge clk);
      a_ivalid_in[0] = 1'b0;
      n_tests++;
      if (a_ivalid !== 1'b0 || a_irdy_out[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_t1: ivalid %b rdy %b required 0 0", a_ivalid, a_irdy_out[0]);
      end
      @(negedge clk);
      n_tests++;
      if (a_ivalid !== 1'b1 || a_addr !== 32'h60 || a_len !== 8'd1 || a_id !== 6'd0) begin
         n_fail++;
         $display("FAIL single_burst: v %b addr %h len %0d id %0d required 1 60 1 0",
                  a_ivalid, a_addr, a_len, a_id);
      end
      wait_done(0, 60, "single");
      repeat (3) @(negedge clk);
      n_tests++;
      if (blk_q.size() != 2 || burst_q.size() != 1) begin
         n_fail++;
         $display("FAIL single_counts: blocks %0d bursts %0d required 2 1", blk_q.size(), burst_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (blk_q[i].d !== pat(32'h60 + 32'(i * 32))) begin
               n_fail++;
               $display("FAIL single_block%0d: got %h required %h", i, blk_q[i].d, pat(32'h60 + 32'(i * 32)));
            end
         end
      end
      n_tests++;
      if (done_cnt[0] != 1 || done_cyc[0] != hand_cyc[0] + 1 || a_irdy_out[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL single_done: cnt %0d done_cyc %0d hand_cyc %0d rdy %b required 1, hand+1, 1",
                  done_cnt[0], done_cyc[0], hand_cyc[0], a_irdy_out[0]);
      end
   endtask

   task automatic test_round_robin();
      int           n0, n1;
      int           exp_id   [4];
      logic [31:0]  exp_addr [4];
      int           exp_len  [4];
      exp_id   = '{0, 1, 0, 0};
      exp_addr = '{32'h0, 32'hC80, 32'h200, 32'h400};
      exp_len  = '{15, 3, 15, 7};
      pulse_reset();
      @(negedge clk);
      a_addr_in[0 +: 25]  = 25'd0;   a_len_in[0 +: 25]  = 25'd40;
      a_addr_in[25 +: 25] = 25'd100; a_len_in[25 +: 25] = 25'd4;
      a_ivalid_in[1:0] = 2'b11;
      @(negedge clk);
      a_ivalid_in[1:0] = 2'b00;
      wait_done(0, 300, "rr");
      repeat (3) @(negedge clk);
      n_tests++;
      if (burst_q.size() != 4) begin
         n_fail++;
         $display("FAIL rr_bursts: got %0d bursts required 4", burst_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (burst_q[i].id != exp_id[i] || burst_q[i].addr !== exp_addr[i] || burst_q[i].len != exp_len[i]) begin
               n_fail++;
               $display("FAIL rr_burst%0d: id %0d addr %h len %0d required %0d %h %0d", i,
                        burst_q[i].id, burst_q[i].addr, burst_q[i].len, exp_id[i], exp_addr[i], exp_len[i]);
            end
         end
      end
      n_tests++;
      if (done_order.size() != 2 || done_order[0] != 1 || done_order[1] != 0) begin
         n_fail++;
         $display("FAIL rr_done_order: %0d pulses, first ch%0d required ch1 then ch0",
                  done_order.size(), (done_order.size() > 0) ? done_order[0] : -1);
      end
      n0 = 0; n1 = 0;
      foreach (blk_q[i]) begin
         n_tests++;
         if (blk_q[i].ch == 0) begin
            if (blk_q[i].d !== pat(32'(n0 * 32))) begin
               n_fail++;
               $display("FAIL rr_ch0_block%0d: got %h required %h", n0, blk_q[i].d, pat(32'(n0 * 32)));
            end
            n0++;
         end else begin
            if (blk_q[i].d !== pat(32'((100 + n1) * 32))) begin
               n_fail++;
               $display("FAIL rr_ch1_block%0d: got %h required %h", n1, blk_q[i].d, pat(32'((100 + n1) * 32)));
            end
            n1++;
         end
      end
      n_tests++;
      if (n0 != 40 || n1 != 4) begin
         n_fail++;
         $display("FAIL rr_block_counts: ch0 %0d ch1 %0d required 40 4", n0, n1);
      end
   endtask

   task automatic test_backpressure();
      int i;
      clear_logs();
      @(negedge clk);
      a_brdy[2] = 1'b0;
      a_addr_in[50 +: 25] = 25'd10; a_len_in[50 +: 25] = 25'd3; a_ivalid_in[2] = 1'b1;
      @(negedge clk);
      a_ivalid_in[2] = 1'b0;
      i = 0;
      while (a_bvalid[2] !== 1'b1 && i < 50) begin
         @(negedge clk);
         i++;
      end
      repeat (4) @(negedge clk);
      n_tests++;
      if (a_drdy !== 1'b0 || a_dvalid !== 1'b1 || a_bvalid[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_stall: drdy %b dvalid %b bvalid %b required 0 1 1", a_drdy, a_dvalid, a_bvalid[2]);
      end
      n_tests++;
      if (a_bdata[512 +: 256] !== pat(32'h140)) begin
         n_fail++;
         $display("FAIL bp_held_block: got %h required %h", a_bdata[512 +: 256], pat(32'h140));
      end
      a_brdy[2] = 1'b1;
      wait_done(2, 60, "bp");
      n_tests++;
      if (blk_q.size() != 3) begin
         n_fail++;
         $display("FAIL bp_count: got %0d blocks required 3", blk_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (blk_q[k].ch != 2 || blk_q[k].d !== pat(32'((10 + k) * 32))) begin
               n_fail++;
               $display("FAIL bp_block%0d: ch %0d got %h required %h", k, blk_q[k].ch, blk_q[k].d,
                        pat(32'((10 + k) * 32)));
            end
         end
      end
   endtask

   task automatic test_zero_length();
      clear_logs();
      @(negedge clk);
      a_addr_in[75 +: 25] = 25'd7; a_len_in[75 +: 25] = 25'd0; a_ivalid_in[3] = 1'b1;
      @(negedge clk);
      a_ivalid_in[3] = 1'b0;
      n_tests++;
      if (a_done[3] !== 1'b1 || a_irdy_out[3] !== 1'b1 || a_ivalid !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_pulse: done %b rdy %b ivalid %b required 1 1 0", a_done[3], a_irdy_out[3], a_ivalid);
      end
      @(negedge clk);
      n_tests++;
      if (a_done[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_single_pulse: done %b required 0", a_done[3]);
      end
      repeat (4) @(negedge clk);
      n_tests++;
      if (burst_q.size() != 0 || a_irdy_out[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL len0_no_burst: bursts %0d rdy %b required 0 1", burst_q.size(), a_irdy_out[3]);
      end
   endtask

   task automatic test_reset_mid_data();
      int i;
      clear_logs();
      @(negedge clk);
      a_addr_in[25 +: 25] = 25'd5; a_len_in[25 +: 25] = 25'd4; a_ivalid_in[1] = 1'b1;
      @(negedge clk);
      a_ivalid_in[1] = 1'b0;
      i = 0;
      while (blk_q.size() == 0 && i < 50) begin
         @(negedge clk);
         i++;
      end
      n_tests++;
      if (a_drdy !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_in_data: drdy %b required 1", a_drdy);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (a_ivalid !== 1'b0 || a_drdy !== 1'b0 || a_bvalid !== 4'h0 || a_irdy_out !== 4'hF || a_done !== 4'h0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: ivalid %b drdy %b bvalid %h rdy %h done %h required 0 0 0 f 0",
                  a_ivalid, a_drdy, a_bvalid, a_irdy_out, a_done);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_logs();
      @(negedge clk);
      a_addr_in[25 +: 25] = 25'd20; a_len_in[25 +: 25] = 25'd1; a_ivalid_in[1] = 1'b1;
      @(negedge clk);
      a_ivalid_in[1] = 1'b0;
      wait_done(1, 60, "rstmid");
      n_tests++;
      if (burst_q.size() != 1 || blk_q.size() != 1) begin
         n_fail++;
         $display("FAIL rstmid_counts: bursts %0d blocks %0d required 1 1", burst_q.size(), blk_q.size());
      end else begin
         n_tests++;
         if (burst_q[0].id != 1 || burst_q[0].addr !== 32'h280 || burst_q[0].len != 0 || blk_q[0].d !== pat(32'h280)) begin
            n_fail++;
            $display("FAIL rstmid_after: id %0d addr %h len %0d data %h required 1 280 0 %h",
                     burst_q[0].id, burst_q[0].addr, burst_q[0].len, blk_q[0].d, pat(32'h280));
         end
      end
   endtask

   task automatic test_wide_block();
      @(negedge clk);
      b_addr_in[0 +: 25] = 25'd2; b_len_in[0 +: 25] = 25'd1; b_ivalid_in[0] = 1'b1;
      @(negedge clk);
      b_ivalid_in[0] = 1'b0;
      @(negedge clk);
      n_tests++;
      if (b_ivalid !== 1'b1 || b_addr !== 32'h80 || b_len !== 8'd1 || b_id !== 6'd0) begin
         n_fail++;
         $display("FAIL wide_burst: v %b addr %h len %0d id %0d required 1 80 1 0", b_ivalid, b_addr, b_len, b_id);
      end
      @(negedge clk);
      b_dvalid = 1'b1; b_ddata = pat(32'h80);
      n_tests++;
      if (b_drdy !== 1'b1) begin
         n_fail++;
         $display("FAIL wide_beat0_rdy: got %b required 1", b_drdy);
      end
      @(negedge clk);
      n_tests++;
      if (b_bvalid[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL wide_early_valid: got %b required 0", b_bvalid[0]);
      end
      b_ddata = pat(32'hA0);
      @(negedge clk);
      b_dvalid = 1'b0;
      n_tests++;
      if (b_bvalid[0] !== 1'b1 || b_bdata[511:0] !== {pat(32'hA0), pat(32'h80)} || b_drdy !== 1'b0) begin
         n_fail++;
         $display("FAIL wide_block: valid %b drdy %b data %h", b_bvalid[0], b_drdy, b_bdata[511:0]);
      end
      b_brdy[0] = 1'b1;
      @(negedge clk);
      n_tests++;
      if (b_done[0] !== 1'b1 || b_bvalid[0] !== 1'b0 || b_irdy_out[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL wide_done: done %b valid %b rdy %b required 1 0 1", b_done[0], b_bvalid[0], b_irdy_out[0]);
      end
      @(negedge clk);
      b_brdy[0] = 1'b0;
      n_tests++;
      if (b_done[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL wide_done_pulse: got %b required 0", b_done[0]);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_addr_in = '0; a_len_in = '0; a_ivalid_in = '0; a_brdy = 4'hF; a_info_rdy = 1'b1;
      b_addr_in = '0; b_len_in = '0; b_ivalid_in = '0; b_brdy = 2'b00; b_info_rdy = 1'b1;
      b_dvalid = 1'b0; b_ddata = '0;
      clear_logs();
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      test_single();
      test_round_robin();
      test_backpressure();
      test_zero_length();
      test_reset_mid_data();
      test_wide_block();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
